// File: rtl/spi_clk_gen_if.sv
// Control/status bundle for spi_clk_gen: transfer setup inputs, SCK and strobe outputs.
// cal_i is present only when SPI_CLK_GEN_CAL_EN is defined.
interface spi_clk_gen_if;
  logic        en_i;
  logic        start_i;
  logic        cpol_i;
  logic        cpha_i;
  logic [15:0] div_i;
  logic [1:0]  tdtb_i;
`ifdef SPI_CLK_GEN_CAL_EN
  logic [15:0] cal_i;
`endif
  logic        busy_o;
  logic        sck_o;
  logic        shift_o;
  logic        sample_o;
  logic        last_o;
  logic        done_o;

  modport master (
    output en_i, start_i, cpol_i, cpha_i, div_i, tdtb_i,
`ifdef SPI_CLK_GEN_CAL_EN
    output cal_i,
`endif
    input  busy_o, sck_o, shift_o, sample_o, last_o, done_o
  );

  modport slave (
    input  en_i, start_i, cpol_i, cpha_i, div_i, tdtb_i,
`ifdef SPI_CLK_GEN_CAL_EN
    input  cal_i,
`endif
    output busy_o, sck_o, shift_o, sample_o, last_o, done_o
  );
endinterface

// File: rtl/spi_clk_gen.sv
// SPI master clock generator: SCK, shift/sample strobes, last/done for 8..32-bit transfers.
// Optional SPI_CLK_GEN_CAL_EN adds a per-transfer sample delay of min(cal, div) cycles.
module spi_clk_gen (
  input logic          clk_i,
  input logic          rst_n_i,
  spi_clk_gen_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HOLD = 2'd2} state_e;

  state_e      state_q, state_d;
  logic [15:0] hcnt_q, hcnt_d;
  logic [6:0]  ecnt_q, ecnt_d;
  logic [5:0]  scnt_q, scnt_d;
  logic        cpol_q, cpol_d, cpha_q, cpha_d;
  logic [15:0] div_q, div_d;
  logic [1:0]  tdtb_q, tdtb_d;
  logic        busy_q, busy_d, sck_q, sck_d, shift_q, shift_d;
  logic        sample_q, sample_d, last_q, last_d, done_q, done_d;

  logic [2:0]  words;
  logic [6:0]  two_n;
  logic [5:0]  n_m1;
  logic        accept, abort, lead, smp_edge, smp_fire;

  // words = N/8, so 2N = 16*words and N-1 = 8*words-1
  assign words = {1'b0, tdtb_q} + 3'd1;
  assign two_n = {words, 4'b0000};
  assign n_m1  = {words, 3'b000} - 6'd1;

`ifdef SPI_CLK_GEN_CAL_EN
  logic [15:0] cal_q, cal_d, dly_q, dly_d, dly_m;
  logic        pend_q, pend_d;
  assign dly_m = (cal_q < div_q) ? cal_q : div_q;
`endif

  always_comb begin
    state_d  = state_q;
    hcnt_d   = hcnt_q;
    ecnt_d   = ecnt_q;
    scnt_d   = scnt_q;
    cpol_d   = cpol_q;
    cpha_d   = cpha_q;
    div_d    = div_q;
    tdtb_d   = tdtb_q;
    sck_d    = sck_q;
    shift_d  = 1'b0;
    sample_d = 1'b0;
    last_d   = 1'b0;
    accept   = 1'b0;
    abort    = 1'b0;
    lead     = 1'b0;
    smp_edge = 1'b0;
    smp_fire = 1'b0;
`ifdef SPI_CLK_GEN_CAL_EN
    cal_d    = cal_q;
    dly_d    = dly_q;
    pend_d   = pend_q;
`endif
    case (state_q)
      IDLE: begin
        sck_d  = bus.cpol_i;
        accept = bus.start_i & bus.en_i;
      end
      RUN: begin
        if (!bus.en_i) begin
          abort = 1'b1;
        end else if (hcnt_q != div_q) begin
          hcnt_d = hcnt_q + 16'd1;
        end else begin
          hcnt_d   = '0;
          sck_d    = ~sck_q;
          ecnt_d   = ecnt_q + 7'd1;
          // edges are numbered from 1, so an even count so far means a leading edge
          lead     = ~ecnt_q[0];
          smp_edge = lead ^ cpha_q;
          shift_d  = cpha_q ? lead : (~lead && (ecnt_d != two_n));
          if (ecnt_d == two_n) state_d = HOLD;
        end
      end
      HOLD: begin
        if (!bus.en_i) begin
          abort = 1'b1;
        end else if (hcnt_q != div_q) begin
          hcnt_d = hcnt_q + 16'd1;
        end else begin
          state_d = IDLE;
          hcnt_d  = '0;
          ecnt_d  = '0;
          sck_d   = bus.cpol_i;
          accept  = bus.start_i & bus.en_i;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef SPI_CLK_GEN_CAL_EN
    // delay never exceeds div, so at most one sample is ever pending
    if (pend_q) begin
      if (dly_q == 16'd1) begin
        smp_fire = 1'b1;
        pend_d   = 1'b0;
      end else begin
        dly_d = dly_q - 16'd1;
      end
    end
    if (smp_edge) begin
      if (dly_m == 16'd0) begin
        smp_fire = 1'b1;
      end else begin
        pend_d = 1'b1;
        dly_d  = dly_m;
      end
    end
`else
    smp_fire = smp_edge;
`endif

    if (smp_fire) begin
      sample_d = 1'b1;
      last_d   = (scnt_q == n_m1);
      scnt_d   = scnt_q + 6'd1;
    end

    if (abort) begin
      state_d  = IDLE;
      hcnt_d   = '0;
      ecnt_d   = '0;
      scnt_d   = '0;
      sck_d    = cpol_q;
      shift_d  = 1'b0;
      sample_d = 1'b0;
      last_d   = 1'b0;
`ifdef SPI_CLK_GEN_CAL_EN
      pend_d   = 1'b0;
`endif
    end

    if (accept) begin
      state_d = RUN;
      hcnt_d  = '0;
      ecnt_d  = '0;
      scnt_d  = '0;
      cpol_d  = bus.cpol_i;
      cpha_d  = bus.cpha_i;
      div_d   = bus.div_i;
      tdtb_d  = bus.tdtb_i;
      sck_d   = bus.cpol_i;
      shift_d = ~bus.cpha_i;
`ifdef SPI_CLK_GEN_CAL_EN
      cal_d   = bus.cal_i;
      pend_d  = 1'b0;
`endif
    end

    busy_d = (state_d != IDLE);
    // done is shown during the last HOLD cycle, so a start there chains directly
    done_d = (state_d == HOLD) && (hcnt_d == div_q);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      hcnt_q   <= '0;
      ecnt_q   <= '0;
      scnt_q   <= '0;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      div_q    <= '0;
      tdtb_q   <= '0;
      busy_q   <= 1'b0;
      sck_q    <= 1'b0;
      shift_q  <= 1'b0;
      sample_q <= 1'b0;
      last_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SPI_CLK_GEN_CAL_EN
      cal_q    <= '0;
      dly_q    <= '0;
      pend_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      hcnt_q   <= hcnt_d;
      ecnt_q   <= ecnt_d;
      scnt_q   <= scnt_d;
      cpol_q   <= cpol_d;
      cpha_q   <= cpha_d;
      div_q    <= div_d;
      tdtb_q   <= tdtb_d;
      busy_q   <= busy_d;
      sck_q    <= sck_d;
      shift_q  <= shift_d;
      sample_q <= sample_d;
      last_q   <= last_d;
      done_q   <= done_d;
`ifdef SPI_CLK_GEN_CAL_EN
      cal_q    <= cal_d;
      dly_q    <= dly_d;
      pend_q   <= pend_d;
`endif
    end
  end

  assign bus.busy_o   = busy_q;
  assign bus.sck_o    = sck_q;
  assign bus.shift_o  = shift_q;
  assign bus.sample_o = sample_q;
  assign bus.last_o   = last_q;
  assign bus.done_o   = done_q;
endmodule
